counter_run_ctrl: RTL

//  Run controller for the synchronous mod-2^WIDTH counter datapath.
//  - Accepts a run request (length) through a valid/ready handshake.
//  - Sequences the counter through clear, count, pause and terminate.
//  - Reports completion with a one-cycle done pulse.
//  - Lets upstream logic issue counting jobs without driving counter enables directly.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_run_ctrl_if.sv | 30 +++
 rtl/counter_mod_n.sv | 29 ++
 rtl/counter_run_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter run controller slice.
//   state_t       : controller state encoding (IDLE/RUN/HOLD/DONE)
//   COUNTER_WIDTH : default counter width
package counter_pkg;

    localparam int unsigned COUNTER_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/counter_run_ctrl_if.sv
// Request/status bundle between a job issuer and counter_run_ctrl.
//   master : issuer side  (drives req_valid, req_len, pause, abort)
//   slave  : controller   (drives req_ready, count, busy, done, aborted)
interface counter_run_ctrl_if
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH
) ();

    logic             req_valid;
    logic [WIDTH-1:0] req_len;
    logic             req_ready;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output req_valid, req_len, pause, abort,
        input  req_ready, count, busy, done, aborted
    );

    modport slave (
        input  req_valid, req_len, pause, abort,
        output req_ready, count, busy, done, aborted
    );

endinterface

// File: rtl/counter_mod_n.sv
// Synchronous mod-2^WIDTH counter datapath.
//   clk : clock (rising edge)
//   rst : asynchronous active-high reset, out -> 0
//   en  : increment (wraps at 2^WIDTH)
//   clr : synchronous clear, wins over en
//   out : registered count value
module counter_mod_n
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else if (clr) begin
            out <= '0;
        end else if (en) begin
            out <= out + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_run_ctrl.sv
// Run controller for the counter datapath: accepts a job length through a
// valid/ready handshake and sequences the counter through clear, count,
// pause and terminate, reporting completion (done) or abort (aborted).
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of counter_run_ctrl_if
//              in : req_valid, req_len, pause, abort
//              out: req_ready (comb, idle), count, busy, done, aborted
// Parameters: WIDTH (counter width), AUTO_RELOAD (restart at terminal count).
module counter_run_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = COUNTER_WIDTH,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    counter_run_ctrl_if.slave   bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] count_w;
    logic             busy_q, done_q, aborted_q;
    logic             cnt_en, cnt_clr, load_len, done_d, aborted_d;
    logic             at_terminal;

    counter_mod_n #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .clr (cnt_clr),
        .out (count_w)
    );

    assign at_terminal = (count_w == len_q);

    // Priority inside an active run: abort > pause > terminal count.
    always_comb begin
        state_d   = state_q;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        load_len  = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    load_len = 1'b1;
                    cnt_clr  = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    cnt_clr   = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (bus.pause) begin
                    state_d = ST_HOLD;
                end else if (at_terminal) begin
                    done_d = 1'b1;
                    if (AUTO_RELOAD) begin
                        // Restart in place; done lines up with count showing 0.
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.abort) begin
                    cnt_clr   = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (!bus.pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
            aborted_q <= aborted_d;
            if (load_len) begin
                len_q <= bus.req_len;
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.count     = count_w;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;

endmodule
